// File: rtl/oled_text_pkg.sv
// Shared types and constants for the OLED character terminal.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package oled_text_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SCROLL = 2'd2
    } state_t;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BLANK = 8'h20;
    localparam logic [7:0] CH_SUBST = 8'h3F;

    // Row storage keeps column i at index i; the display wants column 0 in the MSB byte.
    function automatic logic [127:0] pack_row(input logic [15:0][7:0] row);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[127-8*i -: 8] = row[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/oled_char_decode.sv
// Classifies one received byte into printable / control classes and the glyph to store.
// Latency: combinational.
// Backpressure: none, pure function of the input byte.
module oled_char_decode
    import oled_text_pkg::*;
(
    input  logic [7:0] data,
    output logic       printable,
    output logic       cr,
    output logic       lf,
    output logic       bs,
    output logic       ff,
    output logic       drop,
    output logic [7:0] ch
);

    // Bytes >= 0x7F have no glyph and are shown as '?'; unknown controls are dropped.
    always_comb begin
        printable = 1'b0;
        cr        = 1'b0;
        lf        = 1'b0;
        bs        = 1'b0;
        ff        = 1'b0;
        drop      = 1'b0;
        ch        = data;
        if (data >= 8'h20) begin
            printable = 1'b1;
            if (data >= 8'h7F) begin
                ch = CH_SUBST;
            end
        end else begin
            case (data)
                CH_CR:   cr   = 1'b1;
                CH_LF:   lf   = 1'b1;
                CH_BS:   bs   = 1'b1;
                CH_FF:   ff   = 1'b1;
                default: drop = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/oled_text_buffer.sv
// Four-row 16-column text terminal with cursor, wrap, scroll and redraw request.
// Latency: 2 cycles per byte, 3 when the byte scrolls the screen.
// Backpressure: in_ready high only in idle and not during a clear pulse.
module oled_text_buffer
    import oled_text_pkg::*;
#(
    parameter int         COLS  = 16,
    parameter int         ROWS  = 4,
    parameter logic [7:0] BLANK = CH_BLANK
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         clear,
    output logic [127:0] page0,
    output logic [127:0] page1,
    output logic [127:0] page2,
    output logic [127:0] page3,
    output logic [1:0]   cursor_row,
    output logic [3:0]   cursor_col,
    output logic         refresh_req,
    input  logic         refresh_ack,
    output logic [7:0]   scroll_cnt
);

    localparam logic [3:0] LAST_COL = 4'(COLS - 1);
    localparam logic [1:0] LAST_ROW = 2'(ROWS - 1);

    state_t           state_q, state_d;
    logic [7:0]       byte_q;
    logic [15:0][7:0] text_q [4];
    logic [1:0]       row_q;
    logic [3:0]       col_q;
    logic [7:0]       scroll_q;
    logic             dirty_q;
    logic             req_q;

    logic       d_print, d_cr, d_lf, d_bs, d_ff, d_drop;
    logic [7:0] d_ch;
    logic       need_scroll;
    logic       modify;

    oled_char_decode u_decode (
        .data      (byte_q),
        .printable (d_print),
        .cr        (d_cr),
        .lf        (d_lf),
        .bs        (d_bs),
        .ff        (d_ff),
        .drop      (d_drop),
        .ch        (d_ch)
    );

    // Next state, handshake and the "something visible changed" strobe.
    always_comb begin
        state_d     = state_q;
        in_ready    = 1'b0;
        need_scroll = ((d_print && col_q == LAST_COL) || d_lf) && (row_q == LAST_ROW);
        modify      = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = S_APPLY;
            end
            S_APPLY: begin
                modify  = !d_drop && !(d_bs && col_q == 4'd0);
                state_d = need_scroll ? S_SCROLL : S_IDLE;
            end
            S_SCROLL: begin
                modify  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Clear aborts whatever is in flight and refuses input for that cycle.
        if (clear) begin
            state_d  = S_IDLE;
            in_ready = 1'b0;
            modify   = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Text, cursor and scroll counter update.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int r = 0; r < 4; r++) text_q[r] <= {16{BLANK}};
            byte_q   <= 8'h00;
            row_q    <= 2'd0;
            col_q    <= 4'd0;
            scroll_q <= 8'd0;
        end else if (clear) begin
            for (int r = 0; r < 4; r++) text_q[r] <= {16{BLANK}};
            row_q <= 2'd0;
            col_q <= 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) byte_q <= in_data;
                end
                S_APPLY: begin
                    if (d_print) begin
                        text_q[row_q][col_q] <= d_ch;
                        if (col_q == LAST_COL) begin
                            col_q <= 4'd0;
                            // On the last row the scroll state repositions the cursor.
                            if (row_q != LAST_ROW) row_q <= row_q + 2'd1;
                        end else begin
                            col_q <= col_q + 4'd1;
                        end
                    end else if (d_cr) begin
                        col_q <= 4'd0;
                    end else if (d_lf) begin
                        col_q <= 4'd0;
                        if (row_q != LAST_ROW) row_q <= row_q + 2'd1;
                    end else if (d_bs) begin
                        if (col_q != 4'd0) begin
                            col_q                       <= col_q - 4'd1;
                            text_q[row_q][col_q - 4'd1] <= BLANK;
                        end
                    end else if (d_ff) begin
                        for (int r = 0; r < 4; r++) text_q[r] <= {16{BLANK}};
                        row_q <= 2'd0;
                        col_q <= 4'd0;
                    end
                end
                S_SCROLL: begin
                    text_q[0] <= text_q[1];
                    text_q[1] <= text_q[2];
                    text_q[2] <= text_q[3];
                    text_q[3] <= {16{BLANK}};
                    row_q     <= LAST_ROW;
                    col_q     <= 4'd0;
                    if (scroll_q != 8'hFF) scroll_q <= scroll_q + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Redraw handshake: dirty is consumed when a request is raised, re-armed by any change.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_q   <= 1'b0;
            dirty_q <= 1'b1;
        end else begin
            if (req_q && refresh_ack) begin
                req_q   <= 1'b0;
                dirty_q <= dirty_q || modify;
            end else if (!req_q && dirty_q) begin
                req_q   <= 1'b1;
                dirty_q <= modify;
            end else begin
                dirty_q <= dirty_q || modify;
            end
        end
    end

    assign page0       = pack_row(text_q[0]);
    assign page1       = pack_row(text_q[1]);
    assign page2       = pack_row(text_q[2]);
    assign page3       = pack_row(text_q[3]);
    assign cursor_row  = row_q;
    assign cursor_col  = col_q;
    assign refresh_req = req_q;
    assign scroll_cnt  = scroll_q;

endmodule

// File: doc/oled_text_buffer.md
# oled_text_buffer

Character terminal stage upstream of the OLED display controller. Consumes ASCII bytes from the UART receive FIFO over a valid/ready handshake and maintains four 16-character text pages with a cursor, line wrap, scrolling and control-character handling. Drives the flat 128-bit `Page0`–`Page3` inputs of the display controller. Requests a redraw through a req/ack handshake whenever page content changes.

## Interface
- `COLS`, default 16: characters per page; fixed by the 128-bit page width.
- `ROWS`, default 4: number of pages.
- `BLANK`, default 8'h20: fill character.
- `CLK`  in  1: system clock, 100 MHz.
- `RST_N`  in  1: reset, asynchronous, active-low. One clock; all state resets asynchronously.
- `in_data`  in  8: received byte.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block accepts a byte this cycle.
- `clear`  in  1: synchronous screen clear, single-cycle pulse.
- `page0`..`page3`  out  128 each: row text. Column 0 occupies [127:120]; column 15 occupies [7:0].
- `cursor_row`  out  2: current row.
- `cursor_col`  out  4: current column.
- `refresh_req`  out  1: redraw request, held high until acknowledged.
- `refresh_ack`  in  1: display controller has latched the pages (one-cycle pulse).
- `scroll_cnt`  out  8: number of scrolls, saturates at 255.

## Operation
- FSM states:
  - S_IDLE: `in_ready`=1. On `in_valid`, latch the byte and go to S_APPLY.
  - S_APPLY: decode the byte. Go to S_SCROLL if a row advance is needed at row 3; otherwise go to S_IDLE.
  - S_SCROLL: page0←page1, page1←page2, page2←page3, page3←all BLANK. Cursor goes to (3,0). `scroll_cnt`+1 unless at 255. Go to S_IDLE.
- Byte decode in S_APPLY:
  - 0x20–0x7E, printable: write to (row, col), then advance. If col=15, col←0 and row+1; if row was 3, scroll instead.
  - 0x7F–0xFF: written as "?" (0x3F), with the same advance rules as a printable byte.
  - 0x0D CR: col←0.
  - 0x0A LF: col←0, row+1; scroll if row was 3.
  - 0x08 BS: if col>0, col−1 and write BLANK at the new position. At col 0, no operation.
  - 0x0C FF: all pages BLANK, cursor (0,0).
  - All other bytes below 0x20: discarded, no change, no dirty flag.
- `clear`: same effect as FF.
  - Takes priority in any state and aborts any in-flight S_APPLY/S_SCROLL.
  - The latched byte is dropped. FSM goes to S_IDLE next cycle.
  - `in_ready` is forced to 0 in the cycle `clear` is high.
- Dirty flag: set by any cycle that modifies page content or the cursor.
- Refresh handshake:
  - `refresh_req` rises the cycle after dirty=1 while `refresh_req`=0; dirty clears in that same cycle.
  - `refresh_req` falls the cycle after `refresh_ack`. An ack while `refresh_req`=0 is ignored.
  - Changes made while a request is outstanding set dirty again, so `refresh_req` re-rises the cycle after it falls (minimum one low cycle).

## Timing
- Reset values:
  - pages: all 0x20; cursor (0,0); FSM S_IDLE; `in_ready`=1.
  - `scroll_cnt`=0; `refresh_req`=0.
  - dirty=1, so `refresh_req` rises on the first cycle after reset is released.
- Throughput: one byte per 2 cycles, or 3 cycles when the byte causes a scroll.
- Page outputs update on the clock edge ending S_APPLY or S_SCROLL and are stable until the next modifying edge.
- Reset asserted mid-operation: immediate return to reset values. No partial scroll is visible after release.
- Simultaneous `clear` and `refresh_ack`: both take effect. `refresh_req` drops and the clear sets dirty again.

## Structure
- Package `oled_text_pkg` holds:
  - FSM state enum;
  - control-character constants (CR, LF, BS, FF);
  - BLANK and the substitute character "?";
  - helper function to pack a 16-byte row into 128 bits with column 0 in the MSB.
- Sub-module `oled_char_decode`: combinational byte classifier producing {printable, cr, lf, bs, ff, drop} and the substituted character. Used by S_APPLY.

## Test plan
- Reset release then ack: `refresh_req`=1 on cycle 1; all pages 0x2020…20; after `refresh_ack`, `refresh_req`=0 next cycle.
- Send "AB", CR, "C": page0[127:104]=0x43,0x42,0x20, cursor (0,1); `in_ready` low every second cycle.
- Send 17 printable bytes 'a'…'q': page0 holds 'a'–'p', page1[127:120]='q', cursor (1,1).
- Send 4 LF: after the 4th LF, `scroll_cnt`=1, cursor (3,0), page3 all BLANK; S_SCROLL lasts exactly one cycle.
- BS at col 0 produces no change and no refresh. BS after "XY" blanks 'Y', cursor (0,1). Bytes 0x80 and 0xFF display as 0x3F. Byte 0x07 is dropped.
- Pulse `clear` during S_SCROLL: all pages BLANK, cursor (0,0), `scroll_cnt` unchanged. Assert `RST_N` low mid-byte: outputs return to reset values asynchronously.
